// File: rtl/streaming_sha256.sv
// rtl/streaming_sha256.sv - streaming SHA-256 engine: word-wise input, padding, one round per clock
module streaming_sha256 (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         update,
  input  logic [31:0]  data_in,
  input  logic [2:0]   bytes_valid,
  input  logic         finalize,
  output logic         hash_valid,
  output logic [255:0] hash
);
  typedef enum logic [1:0] {S_IDLE, S_COMPRESS, S_ADD, S_DONE} state_t;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [31:0] H_INIT [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  state_t      r_state;
  logic [31:0] r_h    [8];
  logic [31:0] r_v    [8];
  logic [31:0] r_w    [16];
  logic [31:0] r_buf  [16];
  logic [31:0] r_pend [16];
  logic [5:0]  r_round;
  logic [63:0] r_bitcnt;
  logic        r_pend_v, r_fin, r_len_pend, r_last;

  logic        w_upd, w_blk_done, w_one, w_go;
  logic [3:0]  w_widx;
  logic [5:0]  w_pos;
  logic [31:0] w_mask, w_t1, w_t2, w_wnew;
  logic [31:0] w_pad [16];
  logic [31:0] w_src [16];

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  assign w_upd      = update && (bytes_valid != 3'd0) && (bytes_valid <= 3'd4);
  assign w_widx     = r_bitcnt[8:5];
  assign w_pos      = r_bitcnt[8:3];
  assign w_mask     = ~(32'hFFFF_FFFF >> {bytes_valid, 3'b000});
  assign w_blk_done = w_upd && (bytes_valid == 3'd4) && (w_widx == 4'd15);
  assign w_one      = w_pos < 6'd56;
  assign w_go       = (r_state == S_IDLE) && (r_pend_v || r_len_pend || r_fin);

  // Pad block: words before the current position are message data, then 0x80, then zeros.
  always_comb begin
    for (int j = 0; j < 16; j++) begin
      if (4'(j) < w_pos[5:2])
        w_pad[j] = r_buf[j];
      else if (4'(j) == w_pos[5:2])
        w_pad[j] = ((w_pos[1:0] == 2'd0) ? 32'h0 : r_buf[j]) | (32'h8000_0000 >> {w_pos[1:0], 3'b000});
      else
        w_pad[j] = 32'h0;
    end
    if (w_one) begin
      w_pad[14] = r_bitcnt[63:32];
      w_pad[15] = r_bitcnt[31:0];
    end
    for (int j = 0; j < 16; j++) begin
      if (r_pend_v)        w_src[j] = r_pend[j];
      else if (r_len_pend) w_src[j] = (j == 14) ? r_bitcnt[63:32] : (j == 15) ? r_bitcnt[31:0] : 32'h0;
      else                 w_src[j] = w_pad[j];
    end
  end

  assign w_t1 = r_v[7] + (rotr(r_v[4], 6) ^ rotr(r_v[4], 11) ^ rotr(r_v[4], 25))
              + ((r_v[4] & r_v[5]) ^ (~r_v[4] & r_v[6])) + K[r_round] + r_w[0];
  assign w_t2 = (rotr(r_v[0], 2) ^ rotr(r_v[0], 13) ^ rotr(r_v[0], 22))
              + ((r_v[0] & r_v[1]) ^ (r_v[0] & r_v[2]) ^ (r_v[1] & r_v[2]));
  assign w_wnew = (rotr(r_w[14], 17) ^ rotr(r_w[14], 19) ^ (r_w[14] >> 10)) + r_w[9]
                + (rotr(r_w[1], 7) ^ rotr(r_w[1], 18) ^ (r_w[1] >> 3)) + r_w[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      hash_valid <= 1'b0;
      hash       <= 256'h0;
      r_round    <= 6'd0;
      r_bitcnt   <= 64'd0;
      r_pend_v   <= 1'b0;
      r_fin      <= 1'b0;
      r_len_pend <= 1'b0;
      r_last     <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_h[i] <= H_INIT[i];
        r_v[i] <= 32'h0;
      end
      for (int i = 0; i < 16; i++) begin
        r_w[i]    <= 32'h0;
        r_buf[i]  <= 32'h0;
        r_pend[i] <= 32'h0;
      end
    end else begin
      hash_valid <= 1'b0;
      if (start) begin
        r_state    <= S_IDLE;
        r_bitcnt   <= 64'd0;
        r_pend_v   <= 1'b0;
        r_fin      <= 1'b0;
        r_len_pend <= 1'b0;
        r_last     <= 1'b0;
        for (int i = 0; i < 8; i++)  r_h[i]   <= H_INIT[i];
        for (int i = 0; i < 16; i++) r_buf[i] <= 32'h0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_go) begin
              for (int i = 0; i < 16; i++) r_w[i] <= w_src[i];
              for (int i = 0; i < 8; i++)  r_v[i] <= r_h[i];
              r_round <= 6'd0;
              r_state <= S_COMPRESS;
              if (r_pend_v) begin
                r_pend_v <= 1'b0;
                r_last   <= 1'b0;
              end else if (r_len_pend) begin
                r_len_pend <= 1'b0;
                r_last     <= 1'b1;
              end else begin
                r_fin      <= 1'b0;
                r_len_pend <= !w_one;
                r_last     <= w_one;
              end
            end
          end
          S_COMPRESS: begin
            r_v[0] <= w_t1 + w_t2;
            r_v[1] <= r_v[0];
            r_v[2] <= r_v[1];
            r_v[3] <= r_v[2];
            r_v[4] <= r_v[3] + w_t1;
            r_v[5] <= r_v[4];
            r_v[6] <= r_v[5];
            r_v[7] <= r_v[6];
            for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
            r_w[15] <= w_wnew;
            r_round <= r_round + 6'd1;
            if (r_round == 6'd63) r_state <= S_ADD;
          end
          S_ADD: begin
            for (int i = 0; i < 8; i++) r_h[i] <= r_h[i] + r_v[i];
            r_state <= r_last ? S_DONE : S_IDLE;
            r_last  <= 1'b0;
          end
          default: begin
            hash       <= {r_h[0], r_h[1], r_h[2], r_h[3], r_h[4], r_h[5], r_h[6], r_h[7]};
            hash_valid <= 1'b1;
            r_state    <= S_IDLE;
          end
        endcase
        // Input side runs after the FSM so a same-cycle arrival overrides a consumed flag.
        if (w_upd) begin
          r_buf[w_widx] <= data_in & w_mask;
          r_bitcnt      <= r_bitcnt + {58'd0, bytes_valid, 3'b000};
          if (w_blk_done) begin
            for (int i = 0; i < 15; i++) r_pend[i] <= r_buf[i];
            r_pend[15] <= data_in;
            r_pend_v   <= 1'b1;
          end
        end
        if (finalize) r_fin <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_streaming_sha256.sv
// tb/tb_streaming_sha256.sv - scoreboard bench for streaming_sha256 with known digests
module tb_streaming_sha256;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, update, finalize;
  logic [31:0]  data_in;
  logic [2:0]   bytes_valid;
  logic         hash_valid;
  logic [255:0] hash;

  typedef struct {
    string        tag;
    logic [255:0] d;
    bit           exact;
  } exp_t;

  exp_t         q[$];
  exp_t         e;
  int           n_chk = 0, n_fail = 0;
  int           cyc = 0, fin_cyc = 0, n_valid = 0, v0;
  logic [255:0] last_d = 256'h0;

  localparam logic [255:0] D_A    = 256'hca978112ca1bbdcafac231b39a23dc4da786eff8147c4e72b9807785afee48bb;
  localparam logic [255:0] D_NULL = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_64   = 256'hd53eda7a637c99cc7fb566d96e9fa109bf15c478410a3f5eb4d4c4e26cd081f6;
  localparam logic [255:0] D_65   = 256'h836203944f4c0280461ad73d31457c22ba19d1d99e232dc231000085899e00a2;
  localparam logic [255:0] D_63   = 256'h1b58d00f5b1fbd2a1884d666a2be33c2fa7463dff32cd60ef200c0f750a6b70f;
  localparam logic [255:0] D_71   = 256'h96b437b3df7c62fc877a121b087899f5e36a58f6d87ba52d997e92bb016aa575;
  localparam logic [255:0] D_79   = 256'h1581baebc5f9dcfd89c658b3c3303203fc0e2f93e3f9e0b593d8b2b8112c6eda;

  streaming_sha256 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .update(update), .data_in(data_in),
    .bytes_valid(bytes_valid), .finalize(finalize), .hash_valid(hash_valid), .hash(hash)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && hash_valid) begin
      n_valid++;
      if (q.size() == 0) begin
        check("spurious_valid", 256'd1, 256'd0);
      end else begin
        e = q.pop_front();
        check({e.tag, "_digest"}, hash, e.d);
        if (e.exact) check({e.tag, "_latency"}, 256'(cyc - fin_cyc), 256'd67);
        else         check({e.tag, "_latency_bound"}, 256'((cyc - fin_cyc) <= 201), 256'd1);
        last_d = e.d;
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic [2:0] bv);
    update = 1'b1; data_in = d; bytes_valid = bv;
    @(posedge clk); #1;
    update = 1'b0; data_in = 32'h0; bytes_valid = 3'd0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 450 && q.size() != 0; i++) @(posedge clk);
    #1;
    check({tag, "_drained"}, 256'(q.size()), 256'd0);
    q.delete();
  endtask

  task automatic send_msg(input string tag, input int nw, input logic [31:0] tw,
                          input logic [2:0] tbv, input logic [255:0] d, input bit exact);
    exp_t x;
    pulse_start();
    for (int i = 0; i < nw; i++) send_word(32'h41414141, 3'd4);
    if (tbv != 3'd0) send_word(tw, tbv);
    x.tag = tag; x.d = d; x.exact = exact;
    q.push_back(x);
    finalize = 1'b1;
    @(posedge clk); #1;
    fin_cyc  = cyc;
    finalize = 1'b0;
    wait_done(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; update = 1'b0; finalize = 1'b0;
    data_in = 32'h0; bytes_valid = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hash", hash, 256'h0);
    check("reset_valid", 256'(hash_valid), 256'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send_msg("a", 0, 32'h61000000, 3'd1, D_A, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("hold", hash, D_A);
    send_msg("empty", 0, 32'h0, 3'd0, D_NULL, 1'b1);
    send_msg("b64", 16, 32'h0, 3'd0, D_64, 1'b0);
    send_msg("b65", 16, 32'h41A5A5A5, 3'd1, D_65, 1'b0);
    send_msg("b63", 15, 32'h414141C3, 3'd3, D_63, 1'b0);
    send_msg("b71", 17, 32'h414141C3, 3'd3, D_71, 1'b0);
    send_msg("b79", 19, 32'h414141C3, 3'd3, D_79, 1'b0);

    v0 = n_valid;
    pulse_start();
    check("start_keeps_hash", hash, D_79);
    for (int i = 0; i < 16; i++) send_word(32'h41414141, 3'd4);
    repeat (20) @(posedge clk);
    #1;
    send_msg("abort_a", 0, 32'h61000000, 3'd1, D_A, 1'b1);
    check("abort_valid_count", 256'(n_valid - v0), 256'd1);

    v0 = n_valid;
    pulse_start();
    start = 1'b1; finalize = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; finalize = 1'b0;
    repeat (150) @(posedge clk);
    #1;
    check("start_beats_finalize", 256'(n_valid - v0), 256'd0);
    send_msg("after_ignore_a", 0, 32'h61000000, 3'd1, D_A, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/streaming_sha256.md
# streaming_sha256

Streaming SHA-256 hash engine: accepts a message as a stream of big-endian 32-bit words, each with a final-word byte count. It pads the message, compresses it one round per clock, and presents the 256-bit digest with a single-cycle valid strobe. It sits behind protocol or crypto front-ends, such as signature checks and key derivation, which push message bytes as they arrive and need no backpressure.

## Interface
- No parameters.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  one-cycle pulse; begin a new message and abort any hash in progress.
- `update`  in  1  one-cycle pulse; `data_in`/`bytes_valid` carry message data this cycle.
- `data_in`  in  32  message bytes, left-aligned; first byte in [31:24].
- `bytes_valid`  in  3  number of valid bytes in `data_in` (1..4); 0 or >4 ignored.
- `finalize`  in  1  one-cycle pulse; message complete, pad and produce digest.
- `hash_valid`  out  1  one-cycle pulse; `hash` holds the final digest.
- `hash`  out  256  digest; H0 in [255:224] … H7 in [31:0] (standard hex order).

## Operation
- Reset: `hash_valid`=0, `hash`=0, state IDLE, byte count 0, H = FIPS 180-4 initial values.
- `start`: load H initial values, clear 64-bit message bit count, clear input buffer, state IDLE; `hash` output unchanged.
- `update`: append the top `bytes_valid` bytes of `data_in` to a 16-word input buffer; add 8×`bytes_valid` to the bit count.
- Only the last `update` before `finalize` may have `bytes_valid` < 4. Non-final partial words are unsupported.
- When the buffer holds 16 words, copy it into the working schedule buffer W[0..15] and start compression. The input buffer is free for the next block in the same cycle.
- Compression: state COMPRESS runs 64 rounds, one per cycle. W[t] for t ≥ 16 is computed on the fly from a 16-entry sliding window. State ADD then adds a..h into H (mod 2^32) in 1 cycle.
- `finalize` is latched (pending flag) and processed once no compression is running. Padding:
  - append 0x80 after the last data byte, then zero-fill;
  - if ≥8 bytes remain in the block: write the 64-bit big-endian bit count in words 14–15 and compress one block;
  - otherwise compress the padded block, then a block of zeros plus the length.
  - For an empty message, the pad block is 0x80000000, zeros, length 0.
- After the last ADD: `hash` ← H, `hash_valid` = 1 for exactly one cycle, state IDLE. `hash` holds until the next completion.
- No backpressure. The caller must not complete a further 64-byte block while one block is already waiting for a busy compressor. The engine accepts back-to-back `update` every cycle for any message ≤ 128 bytes.
- `start` during COMPRESS/ADD/PAD: abort, discard the pending block and pending finalize, no `hash_valid`.
- `update` and `finalize` in the same cycle: process the update first.
- `start` together with `update` or `finalize`: `start` wins; the others are ignored.
- Bit count wraps mod 2^64.

## Timing
- States: IDLE → (block full or pad ready) COMPRESS (64 cycles) → ADD (1) → COMPRESS again if a block or second pad block is pending, else IDLE/DONE.
- Each compression takes 66 cycles, including the load cycle.
- `finalize` with the compressor idle and one pad block: `hash_valid` exactly 67 cycles after the `finalize` edge.
- Two pad blocks, or `finalize` while busy: at most 3×67 cycles.
- `hash_valid` is never asserted during `start` or in the cycle after it.

## Test plan
- `start`; update "a" (0x61000000, bv=1); finalize → ca978112ca1bbdcafac231b39a23dc4da786eff8147c4e72b9807785afee48bb.
- `start`; finalize only → e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- 16 × "AAAA" back-to-back (64 bytes), finalize → d53eda7a637c99cc7fb566d96e9fa109bf15c478410a3f5eb4d4c4e26cd081f6.
- 16 × "AAAA" + "A" bv=1 (65 bytes) → 836203944f4c0280461ad73d31457c22ba19d1d99e232dc231000085899e00a2.
- 15 × "AAAA" + "AAA" bv=3 (63 bytes; length spills to a second block) → 1b58d00f5b1fbd2a1884d666a2be33c2fa7463dff32cd60ef200c0f750a6b70f.
- 17 × "AAAA" + "AAA" (71 B) → 96b437b3df7c62fc877a121b087899f5e36a58f6d87ba52d997e92bb016aa575; 19 × "AAAA" + "AAA" (79 B) → 1581baebc5f9dcfd89c658b3c3303203fc0e2f93e3f9e0b593d8b2b8112c6eda.
- Abort case: start mid-compression, then hash "a" → no spurious `hash_valid`, correct "a" digest.
